// File: rtl/mode_reg_seq_pkg.sv
// Shared encodings, config payload and state enumeration for the SDRAM mode-register sequencer.
package mode_reg_seq_pkg;

    // SDRAM command encodings on {ras, cas, we}
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_MRS = 3'b000;

    // Config select value that is never legal for cfg_cl or cfg_bl
    localparam logic [1:0] CFG_INVALID = 2'd3;

    // CAS latency field codes for mode register bits [6:4]
    localparam logic [2:0] CL_CODE_2  = 3'b010;
    localparam logic [2:0] CL_CODE_25 = 3'b110;
    localparam logic [2:0] CL_CODE_3  = 3'b011;

    // Burst length field codes for mode register bits [2:0]
    localparam logic [2:0] BL_CODE_2 = 3'b001;
    localparam logic [2:0] BL_CODE_4 = 3'b010;
    localparam logic [2:0] BL_CODE_8 = 3'b011;

    // Significant width of a mode register word; higher address bits are driven 0
    localparam int unsigned MR_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_RP,
        ST_EMRS,
        ST_WAIT_MRD1,
        ST_MRS,
        ST_WAIT_MRD2,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [1:0] cl;
        logic [1:0] bl;
        logic       bt;
    } cfg_t;

    // Both selects must avoid the reserved encoding
    function automatic logic cfg_valid(cfg_t cfg);
        return (cfg.cl != CFG_INVALID) && (cfg.bl != CFG_INVALID);
    endfunction

    // Build the MRS address word from a latched config
    function automatic logic [MR_W-1:0] mrs_word(cfg_t cfg, logic dll_rst);
        logic [MR_W-1:0] w;
        logic [2:0]      cl_c;
        logic [2:0]      bl_c;
        case (cfg.cl)
            2'd1:    cl_c = CL_CODE_25;
            2'd2:    cl_c = CL_CODE_3;
            default: cl_c = CL_CODE_2;
        endcase
        case (cfg.bl)
            2'd1:    bl_c = BL_CODE_4;
            2'd2:    bl_c = BL_CODE_8;
            default: bl_c = BL_CODE_2;
        endcase
        w      = '0;
        w[2:0] = bl_c;
        w[3]   = cfg.bt;
        w[6:4] = cl_c;
        w[8]   = dll_rst;
        return w;
    endfunction

endpackage

// File: rtl/mode_reg_seq_nop_timer.sv
// Loadable down-counter; zero_c tells the sequencer the command spacing has elapsed.
module nop_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/mode_reg_seq.sv
// SDRAM mode-register programming sequencer: PRECHARGE, optional EMRS, MRS, then DONE.
// ADDR_W must be at least 11; TRP and TMRD must be at least 1.
module mode_reg_seq
    import mode_reg_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned BA_W    = 2,
    parameter int unsigned TRP     = 3,
    parameter int unsigned TMRD    = 2,
    parameter bit          EMRS_EN = 1'b1,
    parameter bit          DLL_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_cl,
    input  logic [1:0]        cfg_bl,
    input  logic              cfg_bt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cke,
    output logic              ras,
    output logic              cas,
    output logic              we,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr
);

    localparam int unsigned T_MAX = (TRP > TMRD) ? TRP : TMRD;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    state_t            state;
    state_t            state_nxt;
    cfg_t              cfg_in;
    cfg_t              cfg_q;
    logic              cfg_ld;
    logic [2:0]        cmd_nxt;
    logic [BA_W-1:0]   ba_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero_c;

    assign cfg_in = {cfg_cl, cfg_bl, cfg_bt};

    nop_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // State, config latch and registered SDRAM pins; reset parks the pins on NOP with CKE low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cfg_q         <= '0;
            cke           <= 1'b0;
            {ras, cas, we} <= CMD_NOP;
            ba            <= '0;
            addr          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            cke           <= 1'b1;
            {ras, cas, we} <= cmd_nxt;
            ba            <= ba_nxt;
            addr          <= addr_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
            if (cfg_ld) begin
                cfg_q <= cfg_in;
            end
        end
    end

    // Next state, then pin values decoded from the state being entered so commands leave the flops aligned with it
    always_comb begin
        state_nxt = state;
        cfg_ld    = 1'b0;
        err_nxt   = 1'b0;
        cmd_nxt   = CMD_NOP;
        ba_nxt    = '0;
        addr_nxt  = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_valid(cfg_in)) begin
                        cfg_ld    = 1'b1;
                        state_nxt = ST_PRE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_PRE, ST_WAIT_RP: begin
                if (tmr_zero_c) begin
                    state_nxt = EMRS_EN ? ST_EMRS : ST_MRS;
                end else begin
                    state_nxt = ST_WAIT_RP;
                end
            end
            ST_EMRS, ST_WAIT_MRD1: begin
                state_nxt = tmr_zero_c ? ST_MRS : ST_WAIT_MRD1;
            end
            ST_MRS, ST_WAIT_MRD2: begin
                state_nxt = tmr_zero_c ? ST_FIN : ST_WAIT_MRD2;
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        case (state_nxt)
            ST_PRE: begin
                cmd_nxt      = CMD_PRE;
                addr_nxt[10] = 1'b1;
                busy_nxt     = 1'b1;
                tmr_load     = 1'b1;
                tmr_val      = CNT_W'(TRP - 1);
            end
            ST_EMRS: begin
                cmd_nxt  = CMD_MRS;
                ba_nxt   = BA_W'(1);
                busy_nxt = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(TMRD - 1);
            end
            ST_MRS: begin
                cmd_nxt  = CMD_MRS;
                addr_nxt = ADDR_W'(mrs_word(cfg_q, DLL_RST));
                busy_nxt = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(TMRD - 1);
            end
            ST_WAIT_RP, ST_WAIT_MRD1, ST_WAIT_MRD2: begin
                busy_nxt = 1'b1;
            end
            ST_FIN: begin
                done_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule
